// File: rtl/ddr3_dqsw_wl_ctrl_pkg.sv
// rtl/ddr3_dqsw_wl_ctrl_pkg.sv - shared types and constants for the DQSW write-leveling controller
package ddr3_wl_pkg;

  // Sweep sequencer states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_PULSE  = 4'd2,
    ST_SETTLE = 4'd3,
    ST_SAMPLE = 4'd4,
    ST_MOVE   = 4'd5,
    ST_GAP    = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } wl_state_e;

  // Error codes reported on TRAIN_ERR_CODE
  localparam logic [1:0] WL_ERR_NONE   = 2'b00;
  localparam logic [1:0] WL_ERR_RANGE  = 2'b01;
  localparam logic [1:0] WL_ERR_NOEDGE = 2'b10;

  // Feedback classification: only both bits high counts as a "one";
  // a mixed value means the DQS edge sits inside the DQ transition
  localparam logic [1:0] WL_FB_ONE = 2'b11;

  function automatic logic wl_is_one(input logic [1:0] rx);
    return (rx == WL_FB_ONE);
  endfunction

endpackage

// File: rtl/ddr3_dqsw_wl_ctrl_if.sv
// rtl/ddr3_dqsw_wl_ctrl_if.sv - sequencer and IOD signal bundle for the write-leveling controller
interface ddr3_dqsw_wl_ctrl_if #(
  parameter int TAP_W = 8
);
  // Training sequencer side
  logic             train_start;
  logic             train_busy;
  logic             train_done;
  logic             train_err;
  logic [1:0]       train_err_code;
  logic [TAP_W-1:0] train_tap;
  // Command sequencer pulse handshake
  logic             pulse_req;
  logic             pulse_ack;
  // IOD side
  logic [1:0]       rx_data;
  logic             delay_line_out_of_range;
  logic             delay_line_move;
  logic             delay_line_direction;
  logic             delay_line_load;
  logic             eye_monitor_clear_flags;

  // Environment: sequencer plus IOD
  modport master (
    output train_start, pulse_ack, rx_data, delay_line_out_of_range,
    input  train_busy, train_done, train_err, train_err_code, train_tap,
           pulse_req, delay_line_move, delay_line_direction,
           delay_line_load, eye_monitor_clear_flags
  );

  // Controller
  modport slave (
    input  train_start, pulse_ack, rx_data, delay_line_out_of_range,
    output train_busy, train_done, train_err, train_err_code, train_tap,
           pulse_req, delay_line_move, delay_line_direction,
           delay_line_load, eye_monitor_clear_flags
  );
endinterface

// File: rtl/ddr3_dqsw_wl_ctrl_edge_filter.sv
// rtl/ddr3_dqsw_wl_ctrl_edge_filter.sv - confirmed 0->1 feedback edge detector
module wl_edge_filter
  import ddr3_wl_pkg::*;
#(
  parameter int TAP_W   = 8,
  parameter int CONFIRM = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_sample,
  input  logic [1:0]       i_rx_data,
  input  logic [TAP_W-1:0] i_tap_cnt,
  output logic             o_edge_found,
  output logic [TAP_W-1:0] o_cand_tap
);

  localparam int CONF_W = $clog2(CONFIRM + 1);

  logic              r_seen_zero;
  logic [CONF_W-1:0] r_conf_cnt;
  logic [TAP_W-1:0]  r_cand;

  logic              w_is_one;
  logic              w_counts;
  logic [CONF_W-1:0] w_conf_nxt;

  assign w_is_one   = wl_is_one(i_rx_data);
  // A "one" only counts once a low window has been seen; earlier ones belong
  // to the previous high window of the DQ feedback
  assign w_counts   = i_sample && w_is_one && r_seen_zero;
  assign w_conf_nxt = r_conf_cnt + CONF_W'(1);

  // The first one of a run is the candidate; later ones keep the stored tap
  assign o_cand_tap   = (r_conf_cnt == '0) ? i_tap_cnt : r_cand;
  assign o_edge_found = w_counts && (w_conf_nxt == CONF_W'(CONFIRM));

  // Track low-window history and the length of the current run of ones
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_seen_zero <= 1'b0;
      r_conf_cnt  <= '0;
      r_cand      <= '0;
    end else if (i_sample) begin
      if (!w_is_one) begin
        r_seen_zero <= 1'b1;
        r_conf_cnt  <= '0;
      end else if (r_seen_zero) begin
        if (r_conf_cnt == '0) begin
          r_cand <= i_tap_cnt;
        end
        r_conf_cnt <= w_conf_nxt;
      end
    end
  end

endmodule

// File: rtl/ddr3_dqsw_wl_ctrl.sv
// rtl/ddr3_dqsw_wl_ctrl.sv - DQSW write-leveling tap sweep controller
module ddr3_dqsw_wl_ctrl
  import ddr3_wl_pkg::*;
#(
  parameter int TAP_W         = 8,
  parameter int MAX_TAPS      = 128,
  parameter int SETTLE_CYCLES = 16,
  parameter int MOVE_GAP      = 4,
  parameter int CONFIRM       = 3
) (
  input logic                  i_fab_clk,
  input logic                  i_reset,
  ddr3_dqsw_wl_ctrl_if.slave   wl
);

  localparam int WAIT_MAX = (SETTLE_CYCLES > MOVE_GAP) ? SETTLE_CYCLES : MOVE_GAP;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST    = WAIT_W'(MOVE_GAP - 1);
  localparam logic [TAP_W-1:0]  TAP_LAST    = TAP_W'(MAX_TAPS - 1);

  wl_state_e         r_state;
  logic [TAP_W-1:0]  r_tap_cnt;
  logic [WAIT_W-1:0] r_wait;

  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic [TAP_W-1:0]  r_train_tap;
  logic              r_pulse_req;
  logic              r_dl_move;
  logic              r_dl_dir;
  logic              r_dl_load;
  logic              r_eye_clr;

  logic              w_start_ok;
  logic              w_sample;
  logic              w_clear;
  logic              w_edge_found;
  logic [TAP_W-1:0]  w_cand_tap;

  assign w_start_ok = wl.train_start &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_sample   = (r_state == ST_SAMPLE);
  assign w_clear    = (r_state == ST_LOAD);

  wl_edge_filter #(
    .TAP_W   (TAP_W),
    .CONFIRM (CONFIRM)
  ) u_edge_filter (
    .i_clk        (i_fab_clk),
    .i_reset      (i_reset),
    .i_clear      (w_clear),
    .i_sample     (w_sample),
    .i_rx_data    (wl.rx_data),
    .i_tap_cnt    (r_tap_cnt),
    .o_edge_found (w_edge_found),
    .o_cand_tap   (w_cand_tap)
  );

  // Sweep sequencer: load, then pulse/settle/sample/move per tap until an edge,
  // the last tap, or an out-of-range delay line
  always_ff @(posedge i_fab_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_tap_cnt   <= '0;
      r_wait      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= WL_ERR_NONE;
      r_train_tap <= '0;
      r_pulse_req <= 1'b0;
      r_dl_move   <= 1'b0;
      r_dl_dir    <= 1'b0;
      r_dl_load   <= 1'b0;
      r_eye_clr   <= 1'b0;
    end else begin
      // Single-cycle strobes default low
      r_dl_move <= 1'b0;
      r_dl_load <= 1'b0;
      r_eye_clr <= 1'b0;

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_start_ok) begin
            r_state    <= ST_LOAD;
            r_dl_load  <= 1'b1;
            r_eye_clr  <= 1'b1;
            r_busy     <= 1'b1;
            r_dl_dir   <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= WL_ERR_NONE;
            r_tap_cnt  <= '0;
            r_wait     <= '0;
          end
        end

        ST_LOAD: begin
          r_state     <= ST_PULSE;
          r_pulse_req <= 1'b1;
        end

        ST_PULSE: begin
          // No timeout: the command sequencer is trusted to answer
          if (wl.pulse_ack) begin
            r_pulse_req <= 1'b0;
            r_wait      <= '0;
            r_state     <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (r_wait == SETTLE_LAST) begin
            r_wait  <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        ST_SAMPLE: begin
          if (w_edge_found) begin
            r_train_tap <= w_cand_tap;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_dl_dir    <= 1'b0;
            r_state     <= ST_DONE;
          end else if (r_tap_cnt == TAP_LAST) begin
            // Last tap checked before any move, so tap_cnt never wraps
            r_err       <= 1'b1;
            r_err_code  <= WL_ERR_NOEDGE;
            r_busy      <= 1'b0;
            r_dl_dir    <= 1'b0;
            r_state     <= ST_ERR;
          end else begin
            r_dl_move   <= 1'b1;
            r_state     <= ST_MOVE;
          end
        end

        ST_MOVE: begin
          r_tap_cnt <= r_tap_cnt + TAP_W'(1);
          r_wait    <= '0;
          r_state   <= ST_GAP;
        end

        ST_GAP: begin
          if (wl.delay_line_out_of_range) begin
            r_train_tap <= r_tap_cnt;
            r_err       <= 1'b1;
            r_err_code  <= WL_ERR_RANGE;
            r_busy      <= 1'b0;
            r_dl_dir    <= 1'b0;
            r_state     <= ST_ERR;
          end else if (r_wait == GAP_LAST) begin
            r_wait      <= '0;
            r_pulse_req <= 1'b1;
            r_state     <= ST_PULSE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wl.train_busy              = r_busy;
  assign wl.train_done              = r_done;
  assign wl.train_err               = r_err;
  assign wl.train_err_code          = r_err_code;
  assign wl.train_tap               = r_train_tap;
  assign wl.pulse_req               = r_pulse_req;
  assign wl.delay_line_move         = r_dl_move;
  assign wl.delay_line_direction    = r_dl_dir;
  assign wl.delay_line_load         = r_dl_load;
  assign wl.eye_monitor_clear_flags = r_eye_clr;

endmodule

// File: doc/ddr3_dqsw_wl_ctrl.md
Name: ddr3_dqsw_wl_ctrl

Overview:
Write-leveling sweep controller for one DDR3 DQSW lane. It sits directly upstream of the lane's DQSW training IOD, driving that IOD's delay-line MOVE/DIRECTION/LOAD and eye-monitor clear inputs and consuming its RX_DATA feedback and out-of-range flag. It steps the DQSW delay one tap at a time, requests a DQS pulse at each tap, and finds the first tap where the DQ feedback makes a confirmed 0->1 transition. It reports that tap, or an error, to the PHY training sequencer.

Parameters:
TAP_W, 8, width of the tap counter and the TRAIN_TAP output.
MAX_TAPS, 128, number of delay taps to sweep, counted from tap 0.
SETTLE_CYCLES, 16, wait in FAB_CLK cycles between pulse ack and feedback sample; must be >=1.
MOVE_GAP, 4, idle cycles after each DELAY_LINE_MOVE pulse; must be >=1.
CONFIRM, 3, consecutive "one" samples required to accept an edge; must be >=1.

Ports:
FAB_CLK  in  1  fabric clock shared with the IOD RX_CLK/TX_CLK.
RESET  in  1  synchronous, active-high reset.
TRAIN_START  in  1  one-cycle start pulse; ignored unless in IDLE, DONE or ERR.
TRAIN_BUSY  out  1  high from LOAD up to, but not including, DONE/ERR.
TRAIN_DONE  out  1  level; high in DONE until the next accepted start or RESET.
TRAIN_ERR  out  1  level; high in ERR until the next accepted start or RESET.
TRAIN_ERR_CODE  out  2  01 = delay line out of range; 10 = no edge found; 00 otherwise.
TRAIN_TAP  out  TAP_W  tap of the first "one" in the confirmed run; valid while TRAIN_DONE is high.
PULSE_REQ  out  1  request to the command sequencer to issue one DQS write-leveling pulse.
PULSE_ACK  in  1  sequencer has issued the pulse.
RX_DATA  in  2  DQ feedback from the IOD.
DELAY_LINE_OUT_OF_RANGE  in  1  from the IOD.
DELAY_LINE_MOVE  out  1  one-cycle tap step pulse.
DELAY_LINE_DIRECTION  out  1  1 while busy (increment), 0 otherwise.
DELAY_LINE_LOAD  out  1  one-cycle pulse that reloads the static delay (tap 0).
EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse, coincident with DELAY_LINE_LOAD.

Behaviour:
- All outputs are registered. On RESET every output is 0, the state is IDLE and all counters are 0. RESET wins over any simultaneous input.
- FSM states: IDLE, LOAD, PULSE, SETTLE, SAMPLE, MOVE, GAP, DONE, ERR.
- Accepted start (edge k in IDLE, DONE or ERR): LOAD is entered at k+1. In LOAD, DELAY_LINE_LOAD=1 and EYE_MONITOR_CLEAR_FLAGS=1 for one cycle; tap_cnt, seen_zero, conf_cnt, TRAIN_DONE, TRAIN_ERR and TRAIN_ERR_CODE are cleared. Next state: PULSE.
- PULSE: PULSE_REQ is held high until PULSE_ACK is sampled high. PULSE_REQ drops on the following cycle and the state moves to SETTLE. There is no timeout.
- SETTLE: counts SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE: one cycle; classifies RX_DATA:
  - 2'b11 = one; anything else = zero (a mixed value is treated as zero).
  - zero: seen_zero=1, conf_cnt=0.
  - one with seen_zero=0: ignored (still in the previous high window).
  - one with seen_zero=1: if conf_cnt==0, cand=tap_cnt; then conf_cnt++.
  - If conf_cnt reaches CONFIRM: TRAIN_TAP=cand, go to DONE.
  - Else, if tap_cnt==MAX_TAPS-1: ERR with code 10.
  - Else: go to MOVE.
- MOVE: DELAY_LINE_MOVE=1 for one cycle, tap_cnt++, then GAP.
- GAP: lasts MOVE_GAP cycles. If DELAY_LINE_OUT_OF_RANGE is high on any GAP cycle, go to ERR with code 01 and TRAIN_TAP=tap_cnt. Otherwise go to PULSE.
- DONE/ERR: TRAIN_BUSY=0, PULSE_REQ=0. The delay line is left at its current tap.
- RESET mid-sweep: the delay line is not restored; the upstream sequencer must retrain.
- Arithmetic: tap_cnt is unsigned TAP_W bits and never wraps, because the MAX_TAPS-1 check precedes any MOVE.

Decomposition:
- Package ddr3_wl_pkg holds:
  - the FSM state enum;
  - the error-code constants WL_ERR_NONE=2'b00, WL_ERR_RANGE=2'b01, WL_ERR_NOEDGE=2'b10;
  - the feedback classification constants.
- One sub-module, wl_edge_filter, holds seen_zero, conf_cnt and cand. Its interface:
  - inputs: sample strobe, RX_DATA, tap_cnt, clear;
  - outputs: edge_found, cand_tap.

Test Plan:
- Reset: hold RESET for 3 cycles with random inputs -> every output is 0 and the state is IDLE; a TRAIN_START during RESET is ignored.
- Clean edge: model returns 00 for taps below 10 and 11 for taps 10 and above -> TRAIN_DONE=1, TRAIN_TAP=10, exactly 12 MOVE pulses, 13 PULSE_REQ handshakes, 1 LOAD pulse.
- Glitch rejection: 11 at tap 5, 00 at tap 6, mixed 01 at taps 7-19, 11 from tap 20 upward -> TRAIN_TAP=20.
- Start inside a high window: 11 for taps 0-30, 00 for taps 31-49, 11 from tap 50 upward -> TRAIN_TAP=50.
- No edge: all 00 -> TRAIN_ERR=1, TRAIN_ERR_CODE=10 after 127 MOVE pulses and 128 samples; TRAIN_BUSY falls in the same cycle.
- Range and restart: DELAY_LINE_OUT_OF_RANGE asserted in GAP after the 40th move -> ERR code 01, TRAIN_TAP=40. Then:
  - TRAIN_START while BUSY is ignored;
  - RESET during PULSE drops PULSE_REQ at the next edge;
  - a new TRAIN_START reissues LOAD.
